// File: rtl/fetch_queue.sv
// Instruction-fetch buffer between the PC/instruction-memory stage and decode.
// Show-ahead FIFO of {pc, instr, exc} with valid/ready handshake and flush.
module fetch_queue #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [WIDTH-1:0]           in_instr,
  input  logic                       in_pc_exp,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_instr,
  output logic                       out_exc,
  output logic [4:0]                 out_exc_code,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [WIDTH-1:0] r_instr_mem [DEPTH];
  logic [DEPTH-1:0] r_exc_mem;

  logic [PtrW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic w_push, w_pop;

  always_comb begin
    in_ready  = (r_count != Full);
    out_valid = (r_count != '0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
  end

  // Pointers and occupancy; flush realigns read to write so stale slots vanish.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exc_mem <= '0;
    end else if (w_push) begin
      r_exc_mem[r_wr_ptr] <= in_pc_exp;
    end
  end

  // An excepting fetch is stored as an all-zero NOP.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= in_pc_exp ? '0 : in_instr;
    end
  end

  always_comb begin
    out_pc       = '0;
    out_instr    = '0;
    out_exc      = 1'b0;
    if (out_valid) begin
      out_pc    = r_pc_mem[r_rd_ptr];
      out_instr = r_instr_mem[r_rd_ptr];
      out_exc   = r_exc_mem[r_rd_ptr];
    end
    out_exc_code = out_exc ? EXC_ADEL : 5'd0;
    count        = r_count;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch buffer directly downstream of the PC register and instruction memory; upstream of decode.
- Each cycle it accepts one {PC, instruction, PC-exception flag} triple and queues it in a small FIFO.
- It presents the oldest entry to decode with a valid/ready handshake.
- It back-pressures the PC register through its stall input, and is flushed on a taken branch, jump or interrupt redirect.

Parameters:
- WIDTH, 32, width of PC and instruction fields.
- DEPTH, 4, number of queue entries; must be a power of two, minimum 2.
- EXC_ADEL, 5'd4, exception code reported for an instruction-fetch address error.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  fetch slot carries a triple this cycle.
- in_pc  input  WIDTH  PC of the fetched instruction (PC register output).
- in_instr  input  WIDTH  instruction word read from instruction memory.
- in_pc_exp  input  1  PC exception flag from the PC register (misaligned or out of 0x3000–0x4FFF).
- in_ready  output  1  queue can accept a push this cycle; the PC register's stall input is driven from !in_ready.
- out_valid  output  1  head entry is valid.
- out_pc  output  WIDTH  PC of the head entry.
- out_instr  output  WIDTH  instruction of the head entry.
- out_exc  output  1  head entry carries a fetch exception.
- out_exc_code  output  5  EXC_ADEL when out_exc=1, else 0.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  discard all entries and the incoming triple (branch, jump or interrupt redirect).
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - DEPTH entries of {pc, instr, exc}, with read pointer, write pointer and count.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Reset (reset_n=0 at the clock edge):
  - count=0, pointers=0, all entry exc bits=0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, out_exc=0, out_exc_code=0, in_ready=1.
  - Reset wins over flush, push and pop in the same cycle.
  - Reset mid-operation discards every entry.
- in_ready = (count != DEPTH). It is combinational from registered state only and never depends on out_ready.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- Push path:
  - On push, write {in_pc, in_pc_exp ? 0 : in_instr, in_pc_exp} at the write pointer; the write pointer then increments.
  - An excepting fetch is stored as a NOP (all-zero instruction).
- Pop path: on pop, the read pointer increments.
- Count update:
  - push&!pop → +1.
  - pop&!push → −1.
  - both or neither → unchanged.
  - Simultaneous push and pop at count=DEPTH is impossible because in_ready=0, so no push occurs.
  - Simultaneous push and pop at count=0 is impossible because out_valid=0, so no pop occurs. No fall-through: a pushed entry appears on the outputs the cycle after the push.
- Output path:
  - Show-ahead: out_valid = (count != 0).
  - out_pc, out_instr and out_exc are read combinationally from the head entry when out_valid=1.
  - All are forced to 0 when out_valid=0.
  - out_exc_code = out_exc ? EXC_ADEL : 0.
- Flush:
  - At the next edge: count=0 and read pointer = write pointer.
  - The incoming triple in the flush cycle is dropped and no pop is counted.
  - in_ready=1 in the following cycle.
- Latency: 1 cycle from push to out_valid when empty. Throughput: 1 entry/cycle sustained when out_ready=1.
- Ordering: strict FIFO. Entries are never duplicated or reordered.
- Out-of-range handling: in_pc_exp is not re-evaluated; the flag is carried exactly as given.

Test Plan:
- Reset then fill: hold reset_n=0 for 2 cycles, then push PC 0x3000/0x3004/0x3008/0x300C with instr 0x24010001..04 and out_ready=0.
  - Required: count reaches 4, in_ready=0 after the 4th push.
  - A 5th in_valid with PC 0x3010 is not stored.
  - out_pc=0x3000, out_instr=0x24010001 throughout.
- Drain in order: from the full state, set out_ready=1 with in_valid=0.
  - Required: out_pc sequence 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles; then out_valid=0, out_pc=0, count=0.
- Streaming and wrap-around: push 10 consecutive PCs from 0x3000 with out_ready=1 every cycle.
  - Required: out_pc equals each input PC exactly one cycle later.
  - count stays ≤1 and pointers wrap past DEPTH with no loss.
- Fetch exception: push in_pc=0x3002, in_instr=0x8C010000, in_pc_exp=1.
  - Required: next cycle out_valid=1, out_pc=0x3002, out_instr=0, out_exc=1, out_exc_code=5'd4.
- Flush with simultaneous push: with 3 entries queued, assert flush and in_valid (PC 0x4000) and out_ready in the same cycle.
  - Required: next cycle count=0, out_valid=0, in_ready=1.
  - A push of PC 0x4000 on the following cycle appears as the head one cycle later.
- Reset mid-operation: with 2 entries queued, drive reset_n=0 together with in_valid=1 and flush=0.
  - Required: next cycle count=0, out_valid=0, all outputs 0, in_ready=1.
